// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - instruction fetch with loader-writable imem and IF/ID pipeline latch
// Priority per edge: reset > halted-hold > flush > stall > capture.
module if_id_stage #(
  parameter int          DATA_WIDTH  = 32,
  parameter int          IMEM_DEPTH  = 256,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_pc,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic                  i_imem_we,
  input  logic [DATA_WIDTH-1:0] i_imem_waddr,
  input  logic [DATA_WIDTH-1:0] i_imem_wdata,
  output logic [DATA_WIDTH-1:0] o_pc_seq,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic [DATA_WIDTH-1:0] o_pc_plus4,
  output logic                  o_valid,
  output logic                  o_halt,
  output logic [DATA_WIDTH-1:0] o_fetch_count
);

  localparam int AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam logic [DATA_WIDTH-1:0] MEM_BYTES = DATA_WIDTH'(4 * IMEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem [IMEM_DEPTH];
  logic [DATA_WIDTH-1:0] fetch_word;
  logic                  fetch_in_range;
  logic                  wr_in_range;

  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] pc_plus4_q, pc_plus4_d;
  logic                  valid_q, valid_d;
  logic                  halt_q, halt_d;
  logic [DATA_WIDTH-1:0] count_q, count_d;

  // Byte-offset bits are don't-care for word-aligned fetch and load.
  logic unused_byte_bits;
  assign unused_byte_bits = ^{i_pc[1:0], i_imem_waddr[1:0]};

  assign o_pc_seq       = i_pc + DATA_WIDTH'(4);
  assign fetch_in_range = (i_pc < MEM_BYTES);
  assign wr_in_range    = (i_imem_waddr < MEM_BYTES);
  assign fetch_word     = fetch_in_range ? mem[i_pc[AW+1:2]] : '0;

  // No reset on the array: contents survive reset, and loader writes land even mid-reset.
  always_ff @(posedge i_clock) begin
    if (i_imem_we && wr_in_range) begin
      mem[i_imem_waddr[AW+1:2]] <= i_imem_wdata;
    end
  end

  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    halt_d     = halt_q;
    count_d    = count_q;
    if (halt_q) begin
      // Frozen until reset.
    end else if (i_flush) begin
      instr_d    = '0;
      pc_plus4_d = o_pc_seq;
      valid_d    = 1'b0;
    end else if (!i_stall) begin
      instr_d    = fetch_word;
      pc_plus4_d = o_pc_seq;
      valid_d    = 1'b1;
      count_d    = count_q + DATA_WIDTH'(1);
      if (fetch_word[31:26] == HALT_OPCODE) begin
        halt_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      instr_q    <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
      halt_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
      halt_q     <= halt_d;
      count_q    <= count_d;
    end
  end

  assign o_instr       = instr_q;
  assign o_pc_plus4    = pc_plus4_q;
  assign o_valid       = valid_q;
  assign o_halt        = halt_q;
  assign o_fetch_count = count_q;

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - scoreboard bench for if_id_stage
// A behavioural model pushes the expected IF/ID state per edge; each test pops and compares.
module tb_if_id_stage;

  logic        i_clock = 1'b0;
  logic        i_reset, i_stall, i_flush, i_imem_we;
  logic [31:0] i_pc, i_imem_waddr, i_imem_wdata;
  logic [31:0] o_pc_seq, o_instr, o_pc_plus4, o_fetch_count;
  logic        o_valid, o_halt;

  if_id_stage dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_pc(i_pc), .i_stall(i_stall), .i_flush(i_flush),
    .i_imem_we(i_imem_we), .i_imem_waddr(i_imem_waddr), .i_imem_wdata(i_imem_wdata),
    .o_pc_seq(o_pc_seq), .o_instr(o_instr), .o_pc_plus4(o_pc_plus4), .o_valid(o_valid),
    .o_halt(o_halt), .o_fetch_count(o_fetch_count)
  );

  always #5 i_clock = ~i_clock;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        halt;
    logic [31:0] count;
  } exp_t;

  typedef struct packed {
    logic        rst;
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
  } stim_t;

  exp_t        sb[$];
  exp_t        mdl;
  logic [31:0] mdl_mem [256];
  int          total = 0;
  int          bad   = 0;

  // Model one edge, queue the expectation, then advance past the edge.
  task automatic drive(input stim_t s);
    logic [31:0] f;
    i_reset = s.rst; i_pc = s.pc; i_stall = s.stall; i_flush = s.flush;
    i_imem_we = s.we; i_imem_waddr = s.waddr; i_imem_wdata = s.wdata;
    f = (s.pc < 32'd1024) ? mdl_mem[s.pc[9:2]] : 32'h0;
    if (s.rst) mdl = '0;
    else if (mdl.halt) mdl = mdl;
    else if (s.flush) begin
      mdl.instr = 32'h0; mdl.valid = 1'b0; mdl.pc4 = s.pc + 32'd4;
    end else if (!s.stall) begin
      mdl.instr = f; mdl.valid = 1'b1; mdl.pc4 = s.pc + 32'd4; mdl.count = mdl.count + 32'd1;
      if (f[31:26] == 6'b111111) mdl.halt = 1'b1;
    end
    if (s.we && s.waddr < 32'd1024) mdl_mem[s.waddr[9:2]] = s.wdata;
    sb.push_back(mdl);
    @(posedge i_clock);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      drive('{1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0});
      e = sb.pop_front();
      total++;
      if ({o_instr, o_pc_plus4, o_valid, o_halt, o_fetch_count} !== e) begin
        bad++;
        $display("FAIL reset[%0d]: got %h want %h", i, {o_instr, o_pc_plus4, o_valid, o_halt, o_fetch_count}, e);
      end
    end
  endtask

  task automatic test_fetch();
    stim_t s[6];
    exp_t  e;
    s = '{'{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0,  32'h20010005},
          '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h4,  32'h20020003},
          '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h8,  32'h01234567},
          '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hC,  32'h12345678},
          '{1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0},
          '{1'b0, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0}};
    for (int i = 0; i < 6; i++) begin
      drive(s[i]);
      e = sb.pop_front();
      total++;
      if ({o_instr, o_pc_plus4, o_valid, o_halt, o_fetch_count} !== e ||
          o_pc_seq !== s[i].pc + 32'd4) begin
        bad++;
        $display("FAIL fetch[%0d]: got %h seq %h want %h seq %h", i,
                 {o_instr, o_pc_plus4, o_valid, o_halt, o_fetch_count}, o_pc_seq, e, s[i].pc + 32'd4);
      end
    end
  endtask

  task automatic test_stall();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      drive('{1'b0, 32'h4, (i < 3), 1'b0, 1'b0, 32'h0, 32'h0});
      e = sb.pop_front();
      total++;
      if ({o_instr, o_pc_plus4, o_valid, o_halt, o_fetch_count} !== e) begin
        bad++;
        $display("FAIL stall[%0d]: got %h want %h", i, {o_instr, o_pc_plus4, o_valid, o_halt, o_fetch_count}, e);
      end
    end
  endtask

  task automatic test_flush();
    exp_t e;
    drive('{1'b0, 32'h8, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0});
    e = sb.pop_front();
    total++;
    if ({o_instr, o_pc_plus4, o_valid, o_halt, o_fetch_count} !== e) begin
      bad++;
      $display("FAIL flush_over_stall: got %h want %h", {o_instr, o_pc_plus4, o_valid, o_halt, o_fetch_count}, e);
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    i_pc = 32'hFFFF_FFFC; i_stall = 1'b0; i_flush = 1'b0;
    #1;
    total++;
    if (o_pc_seq !== 32'h0) begin
      bad++;
      $display("FAIL pc_seq_wrap: got %h want %h", o_pc_seq, 32'h0);
    end
    drive('{1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0});
    e = sb.pop_front();
    total++;
    if ({o_instr, o_pc_plus4, o_valid, o_halt, o_fetch_count} !== e) begin
      bad++;
      $display("FAIL out_of_range_nop: got %h want %h", {o_instr, o_pc_plus4, o_valid, o_halt, o_fetch_count}, e);
    end
  endtask

  task automatic test_write_collision();
    stim_t s[3];
    exp_t  e;
    s = '{'{1'b0, 32'hC, 1'b0, 1'b0, 1'b1, 32'hC,    32'hAAAAAAAA},
          '{1'b0, 32'hC, 1'b0, 1'b0, 1'b1, 32'h1000, 32'h55555555},
          '{1'b0, 32'hC, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0}};
    for (int i = 0; i < 3; i++) begin
      drive(s[i]);
      e = sb.pop_front();
      total++;
      if ({o_instr, o_pc_plus4, o_valid, o_halt, o_fetch_count} !== e) begin
        bad++;
        $display("FAIL collision[%0d]: got %h want %h", i, {o_instr, o_pc_plus4, o_valid, o_halt, o_fetch_count}, e);
      end
    end
  endtask

  task automatic test_halt();
    stim_t s[12];
    exp_t  e;
    s = '{'{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h8,  32'hFC000000},
          '{1'b0, 32'h8,  1'b0, 1'b1, 1'b0, 32'h0,  32'h0},
          '{1'b0, 32'h8,  1'b1, 1'b0, 1'b0, 32'h0,  32'h0},
          '{1'b0, 32'h8,  1'b0, 1'b0, 1'b0, 32'h0,  32'h0},
          '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0,  32'h0},
          '{1'b0, 32'h4,  1'b1, 1'b0, 1'b0, 32'h0,  32'h0},
          '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 32'h10, 32'h11111111},
          '{1'b1, 32'h8,  1'b0, 1'b0, 1'b1, 32'h14, 32'h22222222},
          '{1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,  32'h0},
          '{1'b0, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0},
          '{1'b0, 32'h14, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0},
          '{1'b0, 32'hC,  1'b0, 1'b0, 1'b0, 32'h0,  32'h0}};
    for (int i = 0; i < 12; i++) begin
      drive(s[i]);
      e = sb.pop_front();
      total++;
      if ({o_instr, o_pc_plus4, o_valid, o_halt, o_fetch_count} !== e) begin
        bad++;
        $display("FAIL halt[%0d]: got %h want %h", i, {o_instr, o_pc_plus4, o_valid, o_halt, o_fetch_count}, e);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mdl_mem[i] = 32'h0;
    mdl = '0;
    i_reset = 1'b1; i_pc = 32'h0; i_stall = 1'b0; i_flush = 1'b0;
    i_imem_we = 1'b0; i_imem_waddr = 32'h0; i_imem_wdata = 32'h0;
    test_reset();
    test_fetch();
    test_stall();
    test_flush();
    test_wrap();
    test_write_collision();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
